// File: rtl/nrisc_run_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_run_pkg
// Shared definitions for the nRisc run-control unit:
//   - run-state encoding (IDLE, RESETTING, RUN, HALTED, TIMEOUT)
//   - default halt opcode
//   - saturating increment helper used by the cycle/retire counters
// No ports; imported by nrisc_run_control and nrisc_pc_trace.
// -----------------------------------------------------------------------------
package nrisc_run_pkg;

    // Run-state encoding. Kept as plain constants so the values stay stable
    // for anything that inspects the state vector directly.
    localparam int unsigned RUN_STATE_W  = 3;
    localparam logic [2:0]  ST_IDLE      = 3'd0;
    localparam logic [2:0]  ST_RESETTING = 3'd1;
    localparam logic [2:0]  ST_RUN       = 3'd2;
    localparam logic [2:0]  ST_HALTED    = 3'd3;
    localparam logic [2:0]  ST_TIMEOUT   = 3'd4;

    // Instruction value that stops the core unless overridden.
    localparam logic [7:0]  HALT_OPCODE_DEFAULT = 8'h00;

    // Increment that sticks at max_value instead of wrapping.
    // Operates on 32-bit containers; callers narrow the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/nrisc_pc_trace.sv
// -----------------------------------------------------------------------------
// nrisc_pc_trace
// Circular history of retired PCs. Only built when NRISC_TRACE_EN is defined.
// Ports:
//   clk     in   system clock, posedge
//   reset   in   synchronous active-high reset, clears buffer and pointer
//   clear   in   synchronous clear (run restart), same effect as reset
//   wr_en   in   push wr_pc into the buffer this cycle
//   wr_pc   in   [ADDR_W]        PC to record
//   rd_idx  in   [log2(DEPTH)]   0 = most recent entry, 1 = previous, ...
//   rd_pc   out  [ADDR_W]        combinational read of the selected entry
// Macro: NRISC_TRACE_EN
// -----------------------------------------------------------------------------
`ifdef NRISC_TRACE_EN
module nrisc_pc_trace
    import nrisc_run_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_pc,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [ADDR_W-1:0]        rd_pc
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] buf_q [DEPTH];
    logic [ADDR_W-1:0] buf_d [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q;
    logic [IDX_W-1:0]  wr_ptr_d;
    logic [IDX_W-1:0]  rd_ptr_s;

    // Buffer update: clear wins over a write; the pointer wraps naturally
    // because DEPTH is a power of two.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_d[i] = '0;
            end
            wr_ptr_d = '0;
        end else if (wr_en) begin
            buf_d[wr_ptr_q] = wr_pc;
            wr_ptr_d        = wr_ptr_q + IDX_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Most recent entry sits one slot behind the write pointer.
    always_comb begin
        rd_ptr_s = wr_ptr_q - IDX_W'(1) - rd_idx;
        rd_pc    = buf_q[rd_ptr_s];
    end

    // Buffer storage and write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule
`endif

// File: rtl/nrisc_run_control.sv
// -----------------------------------------------------------------------------
// nrisc_run_control
// Run-control and halt detection for the nRisc system top. Sequences the core
// reset, enables the core only while running, stops on the halt opcode or on
// the cycle watchdog, and reports cycle/retire counts and the halt PC.
// Ports:
//   Clock          in   system clock, all state on posedge
//   Reset          in   synchronous active-high reset
//   Start          in   begin/restart a run (honoured in IDLE, HALTED, TIMEOUT)
//   InstrucaoLida  in   [WORD_W] instruction currently fetched by the core
//   PCOut          in   [ADDR_W] PC of that instruction
//   Retire         in   core completed an instruction this cycle
//   CoreReset      out  core reset, high in IDLE and RESETTING
//   CoreEn         out  core clock enable, high only in RUN
//   Busy           out  high in RESETTING or RUN
//   Halted         out  sticky, run ended on the halt opcode
//   TimedOut       out  sticky, run ended on the watchdog
//   HaltPC         out  [ADDR_W] PC captured at halt detection
//   CycleCount     out  [CNT_W] RUN cycles elapsed, saturating
//   RetireCount    out  [CNT_W] retired instructions in RUN, saturating
//   TraceIdx       in   [log2(TRACE_DEPTH)] PC history select (NRISC_TRACE_EN)
//   TraceData      out  [ADDR_W] selected PC history entry (NRISC_TRACE_EN)
// Macro: NRISC_TRACE_EN adds the PC history buffer and its two ports.
// -----------------------------------------------------------------------------
module nrisc_run_control
    import nrisc_run_pkg::*;
#(
    parameter int unsigned       WORD_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [WORD_W-1:0] HALT_OPCODE = WORD_W'(HALT_OPCODE_DEFAULT),
    parameter int unsigned       CNT_W       = 16,
    parameter int unsigned       MAX_CYCLES  = 1000,
    parameter int unsigned       RST_CYCLES  = 2
`ifdef NRISC_TRACE_EN
   ,parameter int unsigned       TRACE_DEPTH = 8
`endif
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [WORD_W-1:0] InstrucaoLida,
    input  logic [ADDR_W-1:0] PCOut,
    input  logic              Retire,
    output logic              CoreReset,
    output logic              CoreEn,
    output logic              Busy,
    output logic              Halted,
    output logic              TimedOut,
    output logic [ADDR_W-1:0] HaltPC,
    output logic [CNT_W-1:0]  CycleCount,
    output logic [CNT_W-1:0]  RetireCount
`ifdef NRISC_TRACE_EN
   ,input  logic [$clog2(TRACE_DEPTH)-1:0] TraceIdx
   ,output logic [ADDR_W-1:0]              TraceData
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONES  = '1;
    localparam logic [31:0]      CNT_MAX32 = 32'(CNT_ONES);
    // Watchdog fires on the edge where the count still reads MAX_CYCLES-1,
    // so the frozen count ends up exactly MAX_CYCLES.
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_CYCLES - 32'd1);
    localparam logic             WD_EN     = (MAX_CYCLES != 0) ? 1'b1 : 1'b0;
    localparam int unsigned      RST_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 32'd1);

    logic [RUN_STATE_W-1:0] state_q, state_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]       retire_count_q, retire_count_d;
    logic                   halted_q, halted_d;
    logic                   timed_out_q, timed_out_d;
    logic [ADDR_W-1:0]      halt_pc_q, halt_pc_d;
    logic                   core_reset_q, core_reset_d;
    logic                   core_en_q, core_en_d;
    logic                   busy_q, busy_d;
    logic                   halt_hit_s;
    logic                   wd_hit_s;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(32'(value), CNT_MAX32));
    endfunction

    assign halt_hit_s = (InstrucaoLida == HALT_OPCODE);
    assign wd_hit_s   = WD_EN && (cycle_count_q == WD_LAST);

    // Run sequencer: state transitions, counters and halt capture.
    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        cycle_count_d  = cycle_count_q;
        retire_count_d = retire_count_q;
        halted_d       = halted_q;
        timed_out_d    = timed_out_q;
        halt_pc_d      = halt_pc_q;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                if (Start) begin
                    state_d        = ST_RESETTING;
                    rst_cnt_d      = '0;
                    cycle_count_d  = '0;
                    retire_count_d = '0;
                    halted_d       = 1'b0;
                    timed_out_d    = 1'b0;
                    halt_pc_d      = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESETTING: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_RUN: begin
                cycle_count_d = cnt_inc(cycle_count_q);
                // Halt takes priority over the watchdog, and the halt
                // instruction's own Retire pulse is not counted.
                if (halt_hit_s) begin
                    state_d   = ST_HALTED;
                    halted_d  = 1'b1;
                    halt_pc_d = PCOut;
                end else begin
                    if (Retire) begin
                        retire_count_d = cnt_inc(retire_count_q);
                    end else begin
                        retire_count_d = retire_count_q;
                    end
                    if (wd_hit_s) begin
                        state_d     = ST_TIMEOUT;
                        timed_out_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the strobes come straight from flops.
    always_comb begin
        core_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESETTING);
        core_en_d    = (state_d == ST_RUN);
        busy_d       = (state_d == ST_RESETTING) || (state_d == ST_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            rst_cnt_q      <= '0;
            cycle_count_q  <= '0;
            retire_count_q <= '0;
            halted_q       <= 1'b0;
            timed_out_q    <= 1'b0;
            halt_pc_q      <= '0;
            core_reset_q   <= 1'b1;
            core_en_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
            halted_q       <= halted_d;
            timed_out_q    <= timed_out_d;
            halt_pc_q      <= halt_pc_d;
            core_reset_q   <= core_reset_d;
            core_en_q      <= core_en_d;
            busy_q         <= busy_d;
        end
    end

    assign CoreReset   = core_reset_q;
    assign CoreEn      = core_en_q;
    assign Busy        = busy_q;
    assign Halted      = halted_q;
    assign TimedOut    = timed_out_q;
    assign HaltPC      = halt_pc_q;
    assign CycleCount  = cycle_count_q;
    assign RetireCount = retire_count_q;

`ifdef NRISC_TRACE_EN
    logic trace_clear_s;
    logic trace_wr_s;

    // History restarts with every accepted Start and records only the
    // retirements that the retire counter also counts.
    assign trace_clear_s = Start && ((state_q == ST_IDLE) || (state_q == ST_HALTED) ||
                                     (state_q == ST_TIMEOUT));
    assign trace_wr_s    = (state_q == ST_RUN) && Retire && !halt_hit_s;

    nrisc_pc_trace #(
        .DEPTH  (TRACE_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_pc_trace (
        .clk    (Clock),
        .reset  (Reset),
        .clear  (trace_clear_s),
        .wr_en  (trace_wr_s),
        .wr_pc  (PCOut),
        .rd_idx (TraceIdx),
        .rd_pc  (TraceData)
    );
`endif

endmodule

// File: tb/tb_nrisc_run_control.sv
// -----------------------------------------------------------------------------
// tb_nrisc_run_control
// Three instances share Clock/Reset/instruction inputs but have separate Start:
//   dut 0: MAX_CYCLES=20 (normal halt, watchdog, mid-run reset, trace)
//   dut 1: MAX_CYCLES=10 (halt and watchdog on the same edge)
//   dut 2: CNT_W=4, MAX_CYCLES=0 (counter saturation, no watchdog)
// A behavioural model predicts every output each cycle; predictions are queued
// when stimulus is driven and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_nrisc_run_control;

    localparam int M_IDLE = 0, M_RST = 1, M_RUN = 2, M_HALT = 3, M_TMO = 4;

    typedef struct {
        int d;
        int cr, ce, bz, hl, to, hpc, cyc, ret;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic [7:0] instr;
    logic [7:0] pc;
    logic       retire;

    logic       cr_o  [3];
    logic       ce_o  [3];
    logic       bz_o  [3];
    logic       hl_o  [3];
    logic       to_o  [3];
    logic [7:0] hpc_o [3];
    logic [15:0] cyc_o [3];
    logic [15:0] ret_o [3];
    logic [15:0] cyc0, ret0, cyc1, ret1;
    logic [3:0]  cyc2, ret2;

`ifdef NRISC_TRACE_EN
    logic [1:0] trace_idx0;
    logic [2:0] trace_idx12;
    logic [7:0] trace_data0, trace_data1, trace_data2;
`endif

    int   n_vectors     = 0;
    int   n_miscompares = 0;
    exp_t sb_q[$];

    // model state per instance
    int m_state [3];
    int m_rleft [3];
    int m_cyc   [3];
    int m_ret   [3];
    int m_hl    [3];
    int m_to    [3];
    int m_hpc   [3];
    int m_max   [3] = '{20, 10, 0};
    int m_cmax  [3] = '{65535, 65535, 15};

    always #5 clock = ~clock;

    nrisc_run_control #(.MAX_CYCLES(20)
`ifdef NRISC_TRACE_EN
        , .TRACE_DEPTH(4)
`endif
    ) dut0 (
        .Clock(clock), .Reset(reset), .Start(start[0]), .InstrucaoLida(instr), .PCOut(pc),
        .Retire(retire), .CoreReset(cr_o[0]), .CoreEn(ce_o[0]), .Busy(bz_o[0]),
        .Halted(hl_o[0]), .TimedOut(to_o[0]), .HaltPC(hpc_o[0]), .CycleCount(cyc0),
        .RetireCount(ret0)
`ifdef NRISC_TRACE_EN
        , .TraceIdx(trace_idx0), .TraceData(trace_data0)
`endif
    );

    nrisc_run_control #(.MAX_CYCLES(10)) dut1 (
        .Clock(clock), .Reset(reset), .Start(start[1]), .InstrucaoLida(instr), .PCOut(pc),
        .Retire(retire), .CoreReset(cr_o[1]), .CoreEn(ce_o[1]), .Busy(bz_o[1]),
        .Halted(hl_o[1]), .TimedOut(to_o[1]), .HaltPC(hpc_o[1]), .CycleCount(cyc1),
        .RetireCount(ret1)
`ifdef NRISC_TRACE_EN
        , .TraceIdx(trace_idx12), .TraceData(trace_data1)
`endif
    );

    nrisc_run_control #(.CNT_W(4), .MAX_CYCLES(0)) dut2 (
        .Clock(clock), .Reset(reset), .Start(start[2]), .InstrucaoLida(instr), .PCOut(pc),
        .Retire(retire), .CoreReset(cr_o[2]), .CoreEn(ce_o[2]), .Busy(bz_o[2]),
        .Halted(hl_o[2]), .TimedOut(to_o[2]), .HaltPC(hpc_o[2]), .CycleCount(cyc2),
        .RetireCount(ret2)
`ifdef NRISC_TRACE_EN
        , .TraceIdx(trace_idx12), .TraceData(trace_data2)
`endif
    );

    assign cyc_o[0] = cyc0;
    assign ret_o[0] = ret0;
    assign cyc_o[1] = cyc1;
    assign ret_o[1] = ret1;
    assign cyc_o[2] = {12'h000, cyc2};
    assign ret_o[2] = {12'h000, ret2};

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Clock-edge behaviour of one instance, written from the run-control description.
    task automatic model_edge(input int k, input bit rst, input bit st, input logic [7:0] in,
                              input logic [7:0] p, input bit rt);
        bit wd;
        if (rst) begin
            m_state[k] = M_IDLE; m_cyc[k] = 0; m_ret[k] = 0;
            m_hl[k] = 0; m_to[k] = 0; m_hpc[k] = 0;
        end else begin
            case (m_state[k])
                M_IDLE, M_HALT, M_TMO: begin
                    if (st) begin
                        m_state[k] = M_RST; m_rleft[k] = 2; m_cyc[k] = 0; m_ret[k] = 0;
                        m_hl[k] = 0; m_to[k] = 0; m_hpc[k] = 0;
                    end
                end
                M_RST: begin
                    m_rleft[k]--;
                    if (m_rleft[k] == 0) m_state[k] = M_RUN;
                end
                M_RUN: begin
                    wd = (m_max[k] != 0) && (m_cyc[k] == m_max[k] - 1);
                    if (m_cyc[k] < m_cmax[k]) m_cyc[k]++;
                    if (in == 8'h00) begin
                        m_state[k] = M_HALT; m_hl[k] = 1; m_hpc[k] = int'(p);
                    end else begin
                        if (rt && m_ret[k] < m_cmax[k]) m_ret[k]++;
                        if (wd) begin
                            m_state[k] = M_TMO; m_to[k] = 1;
                        end
                    end
                end
                default: m_state[k] = M_IDLE;
            endcase
        end
    endtask

    // Drive one cycle of stimulus, queue predictions, compare after the edge.
    task automatic step(input logic [2:0] st, input logic [7:0] in, input logic [7:0] p,
                        input logic rt, input logic rst);
        exp_t e;
        reset = rst; start = st; instr = in; pc = p; retire = rt;
        for (int k = 0; k < 3; k++) begin
            model_edge(k, rst, st[k], in, p, rt);
            e.d   = k;
            e.cr  = (m_state[k] == M_IDLE || m_state[k] == M_RST) ? 1 : 0;
            e.ce  = (m_state[k] == M_RUN) ? 1 : 0;
            e.bz  = (m_state[k] == M_RST || m_state[k] == M_RUN) ? 1 : 0;
            e.hl  = m_hl[k]; e.to = m_to[k]; e.hpc = m_hpc[k];
            e.cyc = m_cyc[k]; e.ret = m_ret[k];
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_vec($sformatf("d%0d_core_reset", e.d), 32'(cr_o[e.d]), 32'(e.cr));
            check_vec($sformatf("d%0d_core_en", e.d),    32'(ce_o[e.d]), 32'(e.ce));
            check_vec($sformatf("d%0d_busy", e.d),       32'(bz_o[e.d]), 32'(e.bz));
            check_vec($sformatf("d%0d_halted", e.d),     32'(hl_o[e.d]), 32'(e.hl));
            check_vec($sformatf("d%0d_timed_out", e.d),  32'(to_o[e.d]), 32'(e.to));
            check_vec($sformatf("d%0d_halt_pc", e.d),    32'(hpc_o[e.d]), 32'(e.hpc));
            check_vec($sformatf("d%0d_cycles", e.d),     32'(cyc_o[e.d]), 32'(e.cyc));
            check_vec($sformatf("d%0d_retires", e.d),    32'(ret_o[e.d]), 32'(e.ret));
        end
        start = 3'b000;
        reset = 1'b0;
    endtask

    task automatic start_run(input logic [2:0] st);
        step(st, 8'h11, 8'h00, 1'b0, 1'b0);
        step(3'b000, 8'h11, 8'h00, 1'b1, 1'b0);   // Retire during RESETTING is ignored
        step(3'b000, 8'h11, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_state[k] = M_IDLE; m_rleft[k] = 0; m_cyc[k] = 0; m_ret[k] = 0;
            m_hl[k] = 0; m_to[k] = 0; m_hpc[k] = 0;
        end
`ifdef NRISC_TRACE_EN
        trace_idx0  = 2'd0;
        trace_idx12 = 3'd0;
`endif
        // reset state
        step(3'b000, 8'h11, 8'h00, 1'b0, 1'b1);
        step(3'b000, 8'h11, 8'h00, 1'b0, 1'b1);
        step(3'b000, 8'h11, 8'h00, 1'b1, 1'b0);

        // 1: five retires then halt at PC 5; a Start during RUN is ignored
        start_run(3'b001);
        for (int i = 0; i < 5; i++) begin
            step((i == 2) ? 3'b001 : 3'b000, 8'hA0 + 8'(i), 8'(i), 1'b1, 1'b0);
        end
        step(3'b000, 8'h00, 8'h05, 1'b1, 1'b0);
        check_vec("t1_halted", 32'(hl_o[0]), 32'd1);
        check_vec("t1_halt_pc", 32'(hpc_o[0]), 32'h05);
        check_vec("t1_retires", 32'(ret_o[0]), 32'd5);
        check_vec("t1_core_en", 32'(ce_o[0]), 32'd0);
        step(3'b000, 8'h33, 8'h09, 1'b1, 1'b0);

        // 2: watchdog expiry after 20 RUN cycles
        start_run(3'b001);
        for (int i = 0; i < 22; i++) begin
            step(3'b000, 8'h40 + 8'(i), 8'(i), 1'(i % 2), 1'b0);
        end
        check_vec("t2_timed_out", 32'(to_o[0]), 32'd1);
        check_vec("t2_cycles", 32'(cyc_o[0]), 32'd20);
        check_vec("t2_halted", 32'(hl_o[0]), 32'd0);

        // 3: halt on the watchdog edge, halt wins
        start_run(3'b010);
        for (int i = 0; i < 9; i++) begin
            step(3'b000, 8'h55, 8'(i), 1'b1, 1'b0);
        end
        step(3'b000, 8'h00, 8'h3C, 1'b1, 1'b0);
        check_vec("t3_halted", 32'(hl_o[1]), 32'd1);
        check_vec("t3_timed_out", 32'(to_o[1]), 32'd0);
        check_vec("t3_cycles", 32'(cyc_o[1]), 32'd10);

        // 5: 4-bit counters saturate; Start from HALTED clears everything
        start_run(3'b100);
        for (int i = 0; i < 20; i++) begin
            step(3'b000, 8'h77, 8'(i), 1'b1, 1'b0);
        end
        step(3'b000, 8'h00, 8'h99, 1'b0, 1'b0);
        check_vec("t5_cycles_sat", 32'(cyc_o[2]), 32'h0F);
        check_vec("t5_retires_sat", 32'(ret_o[2]), 32'h0F);
        step(3'b100, 8'h11, 8'h00, 1'b0, 1'b0);
        check_vec("t5_clr_retires", 32'(ret_o[2]), 32'd0);
        check_vec("t5_clr_halted", 32'(hl_o[2]), 32'd0);
        check_vec("t5_clr_halt_pc", 32'(hpc_o[2]), 32'd0);

        // 4: reset at RUN cycle 7, then a clean re-run
        start_run(3'b001);
        for (int i = 0; i < 6; i++) begin
            step(3'b000, 8'h21, 8'(i), 1'b1, 1'b0);
        end
        step(3'b000, 8'h00, 8'h07, 1'b1, 1'b1);
        check_vec("t4_core_reset", 32'(cr_o[0]), 32'd1);
        check_vec("t4_cycles", 32'(cyc_o[0]), 32'd0);
        check_vec("t4_halted", 32'(hl_o[0]), 32'd0);
        start_run(3'b001);
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 8'h22, 8'(i), 1'b1, 1'b0);
        end
        step(3'b000, 8'h00, 8'h42, 1'b0, 1'b0);
        check_vec("t4_rerun_halt_pc", 32'(hpc_o[0]), 32'h42);

`ifdef NRISC_TRACE_EN
        // 6: PC history, most recent first
        step(3'b001, 8'h11, 8'h00, 1'b0, 1'b0);
        trace_idx0 = 2'd0;
        #1;
        check_vec("t6_cleared", 32'(trace_data0), 32'd0);
        step(3'b000, 8'h11, 8'h00, 1'b0, 1'b0);
        step(3'b000, 8'h11, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(3'b000, 8'h60, 8'(i), 1'b1, 1'b0);
        end
        step(3'b000, 8'h00, 8'h0E, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            trace_idx0 = 2'(i);
            #1;
            check_vec($sformatf("t6_trace%0d", i), 32'(trace_data0), 32'(6 - i));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
